// File: rtl/len5_csr_pkg.sv
// Shared CSR constants and types for the hardware performance counter bank.
// The mhpmevent OF/OFINH positions are only used when LEN5_HPM_OVERFLOW_IRQ_EN
// is defined.
package len5_csr_pkg;

  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

  // mhpmevent bit positions for the overflow extension
  localparam int HPM_EVT_OF_BIT    = 63;
  localparam int HPM_EVT_OFINH_BIT = 62;

  typedef logic [7:0] hpm_evt_sel_t;

  // WARL legalisation of the selector field: 0 or out-of-range freezes the counter
  function automatic hpm_evt_sel_t sel_legalize(input logic [7:0] v, input int n_evt);
    if ((v == 8'd0) || (int'(v) > n_evt)) return hpm_evt_sel_t'(0);
    return hpm_evt_sel_t'(v);
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One hardware performance counter with its event selector.
// Optional feature macro: LEN5_HPM_OVERFLOW_IRQ_EN adds sticky OF and OFINH
// bits to the selector register and an overflow interrupt request.
module hpm_counter
  import len5_csr_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int N_EVT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_EVT-1:0] evt_i,
  input  logic             inhibit_i,
  input  logic             cnt_we_i,
  input  logic             sel_we_i,
  input  logic [63:0]      wdata_i,
  output logic [63:0]      cnt_rdata_o,
  output logic [63:0]      sel_rdata_o,
  output logic             irq_req_o
);

  logic [CNT_W-1:0] cnt_q;
  hpm_evt_sel_t     sel_q;
  logic             evt_hit;
  logic             inc;
  logic             wrap;
  logic             unused_wdata;

  // Not every write-data bit lands in a register of this counter
  assign unused_wdata = ^wdata_i;

  // Selected event line; selector value k picks evt_i[k-1], 0 selects nothing
  always_comb begin
    evt_hit = 1'b0;
    for (int k = 0; k < N_EVT; k++) begin
      if ((sel_q == hpm_evt_sel_t'(k + 1)) && evt_i[k]) evt_hit = 1'b1;
    end
  end

  // A software write to the counter drops the coincident increment
  assign inc  = evt_hit & ~inhibit_i & ~cnt_we_i;
  assign wrap = inc & (&cnt_q);

  // Counter register: software write wins over increment, wraps modulo 2^CNT_W
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_we_i) begin
      cnt_q <= wdata_i[CNT_W-1:0];
    end else if (inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Event selector register, legalised on write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q <= '0;
    end else if (sel_we_i) begin
      sel_q <= sel_legalize(wdata_i[7:0], N_EVT);
    end
  end

  // Counter read value, zero-extended to 64 bits
  always_comb begin
    cnt_rdata_o = '0;
    cnt_rdata_o[CNT_W-1:0] = cnt_q;
  end

`ifdef LEN5_HPM_OVERFLOW_IRQ_EN
  logic of_q, ofinh_q, of_d, ofinh_d;

  // Next OF/OFINH: software write first, then a wrap forces OF so it is never lost
  always_comb begin
    of_d    = of_q;
    ofinh_d = ofinh_q;
    if (sel_we_i) begin
      of_d    = wdata_i[HPM_EVT_OF_BIT];
      ofinh_d = wdata_i[HPM_EVT_OFINH_BIT];
    end
    if (wrap) of_d = 1'b1;
  end

  // Overflow status flops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      of_q    <= 1'b0;
      ofinh_q <= 1'b0;
    end else begin
      of_q    <= of_d;
      ofinh_q <= ofinh_d;
    end
  end

  // Selector read value with overflow bits
  always_comb begin
    sel_rdata_o = '0;
    sel_rdata_o[7:0] = sel_q;
    sel_rdata_o[HPM_EVT_OF_BIT]    = of_q;
    sel_rdata_o[HPM_EVT_OFINH_BIT] = ofinh_q;
  end

  // Request from next-state values so the top's irq flop rises with the wrap edge
  assign irq_req_o = of_d & ~ofinh_d;
`else
  logic unused_wrap;
  assign unused_wrap = wrap;

  // Selector read value; bits 63:8 read as zero
  always_comb begin
    sel_rdata_o = '0;
    sel_rdata_o[7:0] = sel_q;
  end

  assign irq_req_o = 1'b0;
`endif

endmodule

// File: rtl/hpm_counter_bank.sv
// Parametrised bank of machine hardware performance counters
// (mhpmcounter3.., mhpmevent3.., mcountinhibit[3+]).
// Optional feature macro: LEN5_HPM_OVERFLOW_IRQ_EN enables the overflow
// interrupt; otherwise irq_o is tied low.
//
// CSR handshake: csr_valid_i is a single-cycle request with no ready signal;
// every request is accepted. csr_ack_o pulses exactly one cycle later, and
// csr_err_o/csr_rdata_o are meaningful only while csr_ack_o is high. A reset
// during an access discards its response.
module hpm_counter_bank
  import len5_csr_pkg::*;
#(
  parameter int N_CNT = 4,
  parameter int CNT_W = 64,
  parameter int N_EVT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_EVT-1:0] evt_i,
  input  logic             csr_valid_i,
  input  logic             csr_we_i,
  input  logic [11:0]      csr_addr_i,
  input  logic [63:0]      csr_wdata_i,
  output logic             csr_ack_o,
  output logic             csr_err_o,
  output logic [63:0]      csr_rdata_o,
  output logic             irq_o
);

  logic [N_CNT-1:0] cnt_hit;
  logic [N_CNT-1:0] sel_hit;
  logic [N_CNT-1:0] cnt_we;
  logic [N_CNT-1:0] sel_we;
  logic [N_CNT-1:0] irq_req;
  logic [N_CNT-1:0] inh_q;
  logic             inh_hit;
  logic             addr_ok;
  logic             wr;
  logic [63:0]      cnt_rd [N_CNT];
  logic [63:0]      sel_rd [N_CNT];
  logic [63:0]      rd_mux;

  // Address decode of the implemented counters, selectors and inhibit register
  always_comb begin
    for (int i = 0; i < N_CNT; i++) begin
      cnt_hit[i] = (csr_addr_i == CSR_MHPMCOUNTER3 + 12'(i));
      sel_hit[i] = (csr_addr_i == CSR_MHPMEVENT3 + 12'(i));
    end
    inh_hit = (csr_addr_i == CSR_MCOUNTINHIBIT);
    addr_ok = (|cnt_hit) | (|sel_hit) | inh_hit;
  end

  assign wr     = csr_valid_i & csr_we_i;
  assign cnt_we = {N_CNT{wr}} & cnt_hit;
  assign sel_we = {N_CNT{wr}} & sel_hit;

  // mcountinhibit: only the bits of implemented counters are stored
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inh_q <= '0;
    end else if (wr && inh_hit) begin
      inh_q <= csr_wdata_i[3+N_CNT-1:3];
    end
  end

  for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
    hpm_counter #(
      .CNT_W (CNT_W),
      .N_EVT (N_EVT)
    ) u_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .evt_i       (evt_i),
      .inhibit_i   (inh_q[g]),
      .cnt_we_i    (cnt_we[g]),
      .sel_we_i    (sel_we[g]),
      .wdata_i     (csr_wdata_i),
      .cnt_rdata_o (cnt_rd[g]),
      .sel_rdata_o (sel_rd[g]),
      .irq_req_o   (irq_req[g])
    );
  end

  // Read mux over current register values (pre-update in the request cycle)
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CNT; i++) begin
      if (cnt_hit[i]) rd_mux = cnt_rd[i];
      if (sel_hit[i]) rd_mux = sel_rd[i];
    end
    if (inh_hit) rd_mux[3+N_CNT-1:3] = inh_q;
  end

  // Registered response; rdata is zero for writes and errors
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csr_ack_o   <= 1'b0;
      csr_err_o   <= 1'b0;
      csr_rdata_o <= '0;
    end else begin
      csr_ack_o   <= csr_valid_i;
      csr_err_o   <= csr_valid_i & ~addr_ok;
      csr_rdata_o <= (csr_valid_i && !csr_we_i && addr_ok) ? rd_mux : '0;
    end
  end

`ifdef LEN5_HPM_OVERFLOW_IRQ_EN
  // Overflow interrupt, registered from the counters' next-state OF/OFINH
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |irq_req;
    end
  end
`else
  logic unused_irq;
  assign unused_irq = ^irq_req;
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Self-checking bench for hpm_counter_bank (default parameters).
// Expectations for the overflow feature follow LEN5_HPM_OVERFLOW_IRQ_EN.
module tb_hpm_counter_bank;

`ifdef LEN5_HPM_OVERFLOW_IRQ_EN
  localparam logic HAS_OF = 1'b1;
`else
  localparam logic HAS_OF = 1'b0;
`endif
  localparam logic [63:0] OF_BIT  = HAS_OF ? 64'h8000_0000_0000_0000 : 64'h0;
  localparam logic [63:0] EVT_HI  = HAS_OF ? 64'hC000_0000_0000_0000 : 64'h0;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] evt = '0;
  logic        csr_valid = 1'b0;
  logic        csr_we = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [63:0] csr_wdata = '0;
  logic        csr_ack;
  logic        csr_err;
  logic [63:0] csr_rdata;
  logic        irq;

  always #5 clk = ~clk;

  hpm_counter_bank #(.N_CNT(4), .CNT_W(64), .N_EVT(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .evt_i       (evt),
    .csr_valid_i (csr_valid),
    .csr_we_i    (csr_we),
    .csr_addr_i  (csr_addr),
    .csr_wdata_i (csr_wdata),
    .csr_ack_o   (csr_ack),
    .csr_err_o   (csr_err),
    .csr_rdata_o (csr_rdata),
    .irq_o       (irq)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [64:0] exp_q[$];   // {err, rdata}
  int          tag_q[$];
  int          cur_tag = 0;
  logic        exp_ack;

  task automatic check(input string name, input int tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (tag %0d): got 0x%h expected 0x%h", name, tag, act, exp);
    end
  endtask

  // Latency model: a request accepted at an edge is answered at the next one
  always @(posedge clk or posedge rst) begin
    if (rst) exp_ack <= 1'b0;
    else     exp_ack <= csr_valid;
  end

  // Response monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst && (csr_ack || exp_ack)) begin
      check("ack", cur_tag, 64'(csr_ack), 64'(exp_ack));
      if (exp_ack) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", cur_tag, 64'(1), 64'(0));
        end else begin
          logic [64:0] e;
          int t;
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          check("err", t, 64'(csr_err), 64'(e[64]));
          check("rdata", t, csr_rdata, e[63:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // One clock cycle of stimulus; a valid request queues its expected response
  task automatic step(input logic v, input logic we, input logic [11:0] a,
                      input logic [63:0] d, input logic [15:0] e,
                      input logic xe, input logic [63:0] xr);
    @(posedge clk);
    #1;
    csr_valid = v;
    csr_we    = we;
    csr_addr  = a;
    csr_wdata = d;
    evt       = e;
    cur_tag++;
    if (v) begin
      exp_q.push_back({xe, xr});
      tag_q.push_back(cur_tag);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 12'h0, 64'h0, 16'h0, 1'b0, 64'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic        we;
    logic [11:0] a;
    logic [63:0] d;
    logic [15:0] e;
    logic        xe;
    logic [63:0] xr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t rd(input logic [11:0] a, input logic [15:0] e, input logic xe, input logic [63:0] xr);
    vec_t r;
    r.v = 1'b1; r.we = 1'b0; r.a = a; r.d = '0; r.e = e; r.xe = xe; r.xr = xr;
    return r;
  endfunction

  function automatic vec_t wr(input logic [11:0] a, input logic [63:0] d, input logic [15:0] e, input logic xe);
    vec_t r;
    r.v = 1'b1; r.we = 1'b1; r.a = a; r.d = d; r.e = e; r.xe = xe; r.xr = '0;
    return r;
  endfunction

  function automatic vec_t ev(input logic [15:0] e);
    vec_t r;
    r.v = 1'b0; r.we = 1'b0; r.a = '0; r.d = '0; r.e = e; r.xe = 1'b0; r.xr = '0;
    return r;
  endfunction

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("reset_ack", 0, 64'(csr_ack), 64'(0));
    check("reset_err", 0, 64'(csr_err), 64'(0));
    check("reset_rdata", 0, csr_rdata, 64'(0));
    check("reset_irq", 0, 64'(irq), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset values, back-to-back reads
    vecs.push_back(rd(12'hB03, 16'h0, 1'b0, 64'd0));
    vecs.push_back(rd(12'h323, 16'h0, 1'b0, 64'd0));
    vecs.push_back(rd(12'h320, 16'h0, 1'b0, 64'd0));
    // 2: select evt_i[1], count 5 pulses, evt_i[0] ignored
    vecs.push_back(wr(12'h323, 64'd2, 16'h0, 1'b0));
    for (int i = 0; i < 5; i++) vecs.push_back(ev(16'h0002));
    for (int i = 0; i < 2; i++) vecs.push_back(ev(16'h0001));
    vecs.push_back(rd(12'hB03, 16'h0, 1'b0, 64'd5));
    vecs.push_back(rd(12'h323, 16'h0, 1'b0, 64'd2));
    // selector write takes effect only from the next cycle's events
    vecs.push_back(wr(12'h324, 64'd1, 16'h0001, 1'b0));
    vecs.push_back(ev(16'h0000));
    vecs.push_back(rd(12'hB04, 16'h0, 1'b0, 64'd0));
    vecs.push_back(ev(16'h0001));
    vecs.push_back(rd(12'hB04, 16'h0, 1'b0, 64'd1));
    // 3: inhibit counter 3+0
    vecs.push_back(wr(12'h320, 64'h8, 16'h0, 1'b0));
    for (int i = 0; i < 3; i++) vecs.push_back(ev(16'h0002));
    vecs.push_back(rd(12'hB03, 16'h0, 1'b0, 64'd5));
    vecs.push_back(rd(12'h320, 16'h0, 1'b0, 64'h8));
    vecs.push_back(wr(12'h320, 64'h0, 16'h0, 1'b0));
    vecs.push_back(ev(16'h0002));
    vecs.push_back(rd(12'hB03, 16'h0, 1'b0, 64'd6));
    vecs.push_back(wr(12'h320, ONES, 16'h0, 1'b0));
    vecs.push_back(rd(12'h320, 16'h0, 1'b0, 64'h78));
    vecs.push_back(wr(12'h320, 64'h0, 16'h0, 1'b0));
    // 4: WARL selector and unimplemented addresses
    vecs.push_back(wr(12'h323, 64'hFF, 16'h0, 1'b0));
    vecs.push_back(rd(12'h323, 16'h0, 1'b0, 64'd0));
    vecs.push_back(wr(12'h323, 64'd17, 16'h0, 1'b0));
    vecs.push_back(rd(12'h323, 16'h0, 1'b0, 64'd0));
    vecs.push_back(wr(12'h323, 64'd16, 16'h0, 1'b0));
    vecs.push_back(rd(12'h323, 16'h0, 1'b0, 64'd16));
    vecs.push_back(rd(12'hB07, 16'h0, 1'b1, 64'd0));
    vecs.push_back(wr(12'hB07, 64'd55, 16'h0, 1'b1));
    vecs.push_back(rd(12'h327, 16'h0, 1'b1, 64'd0));
    vecs.push_back(rd(12'h000, 16'h0, 1'b1, 64'd0));
    vecs.push_back(rd(12'h31F, 16'h0, 1'b1, 64'd0));
    vecs.push_back(rd(12'hB06, 16'h0, 1'b0, 64'd0));
    vecs.push_back(wr(12'h323, 64'hC000_0000_0000_0002, 16'h0, 1'b0));
    vecs.push_back(rd(12'h323, 16'h0, 1'b0, EVT_HI | 64'd2));
    vecs.push_back(wr(12'h323, 64'd2, 16'h0, 1'b0));
    vecs.push_back(rd(12'h323, 16'h0, 1'b0, 64'd2));
    vecs.push_back(rd(12'hB03, 16'h0, 1'b0, 64'd6));
    // 5: write wins over coincident event; read returns pre-increment value
    vecs.push_back(wr(12'hB03, 64'd100, 16'h0002, 1'b0));
    vecs.push_back(rd(12'hB03, 16'h0, 1'b0, 64'd100));
    vecs.push_back(rd(12'hB03, 16'h0002, 1'b0, 64'd100));
    vecs.push_back(rd(12'hB03, 16'h0, 1'b0, 64'd101));

    foreach (vecs[i]) step(vecs[i].v, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].e, vecs[i].xe, vecs[i].xr);
    idle();

    // 6: wrap, overflow flag and interrupt
    step(1'b1, 1'b1, 12'hB03, ONES, 16'h0, 1'b0, 64'd0);
    step(1'b0, 1'b0, 12'h0, 64'd0, 16'h0002, 1'b0, 64'd0);
    @(negedge clk);
    check("irq_before_wrap", cur_tag, 64'(irq), 64'(0));
    step(1'b1, 1'b0, 12'hB03, 64'd0, 16'h0, 1'b0, 64'd0);
    @(negedge clk);
    check("irq_after_wrap", cur_tag, 64'(irq), 64'(HAS_OF));
    step(1'b1, 1'b0, 12'h323, 64'd0, 16'h0, 1'b0, OF_BIT | 64'd2);
    step(1'b1, 1'b1, 12'h323, 64'hC000_0000_0000_0002, 16'h0, 1'b0, 64'd0);
    idle();
    @(negedge clk);
    check("irq_ofinh", cur_tag, 64'(irq), 64'(0));
    step(1'b1, 1'b0, 12'h323, 64'd0, 16'h0, 1'b0, EVT_HI | 64'd2);
    // wrap in the same cycle as a software clear of OF keeps OF set
    step(1'b1, 1'b1, 12'h323, 64'd2, 16'h0, 1'b0, 64'd0);
    step(1'b1, 1'b1, 12'hB03, ONES, 16'h0, 1'b0, 64'd0);
    step(1'b1, 1'b1, 12'h323, 64'd2, 16'h0002, 1'b0, 64'd0);
    step(1'b1, 1'b0, 12'h323, 64'd0, 16'h0, 1'b0, OF_BIT | 64'd2);
    @(negedge clk);
    check("irq_wrap_vs_clear", cur_tag, 64'(irq), 64'(HAS_OF));
    step(1'b1, 1'b0, 12'hB03, 64'd0, 16'h0, 1'b0, 64'd0);
    step(1'b1, 1'b1, 12'h323, 64'd2, 16'h0, 1'b0, 64'd0);
    idle();
    @(negedge clk);
    check("irq_cleared", cur_tag, 64'(irq), 64'(0));
    idle();
    idle();

    // reset in the middle of an access: no response afterwards
    @(posedge clk);
    #1;
    csr_valid = 1'b1;
    csr_we    = 1'b0;
    csr_addr  = 12'hB03;
    #2 rst = 1'b1;
    @(posedge clk);
    #1 csr_valid = 1'b0;
    @(negedge clk);
    check("ack_in_reset", cur_tag, 64'(csr_ack), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ack_after_reset", cur_tag, 64'(csr_ack), 64'(0));
    end
    step(1'b1, 1'b0, 12'hB03, 64'd0, 16'h0, 1'b0, 64'd0);
    step(1'b1, 1'b0, 12'h323, 64'd0, 16'h0, 1'b0, 64'd0);
    step(1'b1, 1'b0, 12'h320, 64'd0, 16'h0, 1'b0, 64'd0);
    idle();
    idle();
    idle();
    @(negedge clk);
    check("queue_drained", cur_tag, 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
